// File: rtl/nfca_pkg.sv
// Shared definitions for the ISO14443A receive path.
package nfca_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrop
  } nfca_rx_state_e;

  localparam int unsigned NFCA_BITS_PER_BYTE = 8;

  // Returns 1 when data plus parity bit do not carry an odd number of ones.
  function automatic logic nfca_odd_par_err(input logic [7:0] data, input logic par);
    return ~^{data, par};
  endfunction

endpackage

// File: rtl/nfca_rx_tobytes.sv
// Byte assembler for the PICC-to-PCD receive path: groups LSB-first data bits into bytes,
// checks odd parity, flushes partial final bytes and issues one frame summary per frame.
module nfca_rx_tobytes
  import nfca_pkg::*;
#(
  parameter int unsigned  MAX_BYTES = 64,
  localparam int unsigned W         = $clog2(MAX_BYTES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_bit_en,
  input  logic         rx_bit,
  input  logic         rx_end,
  input  logic         rx_end_err,
  input  logic         rx_end_col,
  output logic         rx_byte_en,
  output logic [7:0]   rx_byte,
  output logic [3:0]   rx_byte_bits,
  output logic         rx_byte_par_err,
  output logic         rx_frame_end,
  output logic         rx_frame_err,
  output logic         rx_frame_ovf,
  output logic         rx_frame_col,
  output logic         rx_frame_par_err,
  output logic [W-1:0] rx_frame_nbytes,
  output logic [3:0]   rx_frame_lastbits,
  output logic [W+2:0] rx_frame_colpos
);

  localparam logic [W-1:0] MaxBytesW = W'(MAX_BYTES);
  localparam logic [3:0]   ParBitCnt = 4'(NFCA_BITS_PER_BYTE);

  nfca_rx_state_e r_state, w_state_d;
  logic [7:0]     r_shreg, w_shreg_d;
  logic [3:0]     r_bitcnt, w_bitcnt_d;
  logic [W-1:0]   r_nbytes, w_nbytes_d;
  logic [W+2:0]   r_dbits, w_dbits_d;
  logic           r_par_err, w_par_err_d;
  // Frame summary deferred by one cycle behind a flushed partial byte.
  logic           r_pend, w_pend_d;
  logic           r_pend_err, w_pend_err_d;
  logic           r_pend_col, w_pend_col_d;
  logic [3:0]     r_pend_lastbits, w_pend_lastbits_d;

  logic           w_byte_en_d, w_byte_par_err_d;
  logic [7:0]     w_byte_d;
  logic [3:0]     w_byte_bits_d;
  logic           w_frame_end_d, w_frame_err_d, w_frame_ovf_d, w_frame_col_d, w_frame_par_err_d;
  logic [W-1:0]   w_frame_nbytes_d;
  logic [3:0]     w_frame_lastbits_d;
  logic [W+2:0]   w_frame_colpos_d;
  logic           w_perr;

  assign w_perr = nfca_odd_par_err(r_shreg, rx_bit);

  // Next-state and output decode: a coincident bit is applied before the end strobe.
  always_comb begin
    w_state_d          = r_state;
    w_shreg_d          = r_shreg;
    w_bitcnt_d         = r_bitcnt;
    w_nbytes_d         = r_nbytes;
    w_dbits_d          = r_dbits;
    w_par_err_d        = r_par_err;
    w_pend_d           = 1'b0;
    w_pend_err_d       = r_pend_err;
    w_pend_col_d       = r_pend_col;
    w_pend_lastbits_d  = r_pend_lastbits;
    w_byte_en_d        = 1'b0;
    w_byte_d           = rx_byte;
    w_byte_bits_d      = rx_byte_bits;
    w_byte_par_err_d   = rx_byte_par_err;
    w_frame_end_d      = 1'b0;
    w_frame_err_d      = rx_frame_err;
    w_frame_ovf_d      = rx_frame_ovf;
    w_frame_col_d      = rx_frame_col;
    w_frame_par_err_d  = rx_frame_par_err;
    w_frame_nbytes_d   = rx_frame_nbytes;
    w_frame_lastbits_d = rx_frame_lastbits;
    w_frame_colpos_d   = rx_frame_colpos;

    if (r_pend) begin
      // Second half of a flush; inputs in this cycle are ignored.
      w_frame_end_d      = 1'b1;
      w_frame_err_d      = r_pend_err;
      w_frame_ovf_d      = 1'b0;
      w_frame_col_d      = r_pend_col;
      w_frame_par_err_d  = r_par_err;
      w_frame_nbytes_d   = r_nbytes;
      w_frame_lastbits_d = r_pend_lastbits;
      w_frame_colpos_d   = r_pend_col ? r_dbits : '0;
    end else begin
      if (rx_bit_en) begin
        unique case (r_state)
          StIdle: begin
            w_shreg_d    = '0;
            w_shreg_d[0] = rx_bit;
            w_bitcnt_d   = 4'd1;
            w_nbytes_d   = '0;
            w_dbits_d    = (W+3)'(1);
            w_par_err_d  = 1'b0;
            w_state_d    = StRecv;
          end
          StRecv: begin
            if (r_bitcnt == 4'd0 && r_nbytes == MaxBytesW) begin
              w_state_d = StDrop;
            end else if (r_bitcnt < ParBitCnt) begin
              if (r_bitcnt == 4'd0) w_shreg_d = '0;
              w_shreg_d[r_bitcnt[2:0]] = rx_bit;
              w_bitcnt_d               = r_bitcnt + 4'd1;
              w_dbits_d                = r_dbits + (W+3)'(1);
            end else begin
              w_byte_en_d      = 1'b1;
              w_byte_d         = r_shreg;
              w_byte_bits_d    = ParBitCnt;
              w_byte_par_err_d = w_perr;
              w_par_err_d      = r_par_err | w_perr;
              w_nbytes_d       = r_nbytes + W'(1);
              w_bitcnt_d       = 4'd0;
            end
          end
          default: ;
        endcase
      end

      if (rx_end) begin
        unique case (w_state_d)
          StIdle: begin
            w_frame_end_d      = 1'b1;
            w_frame_err_d      = rx_end_err;
            w_frame_ovf_d      = 1'b0;
            w_frame_col_d      = rx_end_col;
            w_frame_par_err_d  = 1'b0;
            w_frame_nbytes_d   = '0;
            w_frame_lastbits_d = 4'd0;
            w_frame_colpos_d   = '0;
          end
          StRecv: begin
            if (w_bitcnt_d != 4'd0) begin
              w_byte_en_d       = 1'b1;
              w_byte_d          = w_shreg_d;
              w_byte_bits_d     = w_bitcnt_d;
              w_byte_par_err_d  = 1'b0;
              w_nbytes_d        = w_nbytes_d + W'(1);
              w_pend_d          = 1'b1;
              w_pend_err_d      = rx_end_err;
              w_pend_col_d      = rx_end_col;
              w_pend_lastbits_d = w_bitcnt_d;
              w_bitcnt_d        = 4'd0;
            end else begin
              w_frame_end_d      = 1'b1;
              w_frame_err_d      = rx_end_err;
              w_frame_ovf_d      = 1'b0;
              w_frame_col_d      = rx_end_col;
              w_frame_par_err_d  = w_par_err_d;
              w_frame_nbytes_d   = w_nbytes_d;
              w_frame_lastbits_d = 4'd0;
              w_frame_colpos_d   = rx_end_col ? w_dbits_d : '0;
            end
            w_state_d = StIdle;
          end
          default: begin
            w_frame_end_d      = 1'b1;
            w_frame_err_d      = 1'b1;
            w_frame_ovf_d      = 1'b1;
            w_frame_col_d      = rx_end_col;
            w_frame_par_err_d  = w_par_err_d;
            w_frame_nbytes_d   = MaxBytesW;
            w_frame_lastbits_d = 4'd0;
            w_frame_colpos_d   = rx_end_col ? w_dbits_d : '0;
            w_state_d          = StIdle;
          end
        endcase
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= StIdle;
      r_shreg           <= '0;
      r_bitcnt          <= '0;
      r_nbytes          <= '0;
      r_dbits           <= '0;
      r_par_err         <= 1'b0;
      r_pend            <= 1'b0;
      r_pend_err        <= 1'b0;
      r_pend_col        <= 1'b0;
      r_pend_lastbits   <= '0;
      rx_byte_en        <= 1'b0;
      rx_byte           <= '0;
      rx_byte_bits      <= '0;
      rx_byte_par_err   <= 1'b0;
      rx_frame_end      <= 1'b0;
      rx_frame_err      <= 1'b0;
      rx_frame_ovf      <= 1'b0;
      rx_frame_col      <= 1'b0;
      rx_frame_par_err  <= 1'b0;
      rx_frame_nbytes   <= '0;
      rx_frame_lastbits <= '0;
      rx_frame_colpos   <= '0;
    end else begin
      r_state           <= w_state_d;
      r_shreg           <= w_shreg_d;
      r_bitcnt          <= w_bitcnt_d;
      r_nbytes          <= w_nbytes_d;
      r_dbits           <= w_dbits_d;
      r_par_err         <= w_par_err_d;
      r_pend            <= w_pend_d;
      r_pend_err        <= w_pend_err_d;
      r_pend_col        <= w_pend_col_d;
      r_pend_lastbits   <= w_pend_lastbits_d;
      rx_byte_en        <= w_byte_en_d;
      rx_byte           <= w_byte_d;
      rx_byte_bits      <= w_byte_bits_d;
      rx_byte_par_err   <= w_byte_par_err_d;
      rx_frame_end      <= w_frame_end_d;
      rx_frame_err      <= w_frame_err_d;
      rx_frame_ovf      <= w_frame_ovf_d;
      rx_frame_col      <= w_frame_col_d;
      rx_frame_par_err  <= w_frame_par_err_d;
      rx_frame_nbytes   <= w_frame_nbytes_d;
      rx_frame_lastbits <= w_frame_lastbits_d;
      rx_frame_colpos   <= w_frame_colpos_d;
    end
  end

endmodule
